wght_ram_mp: RTL and testbench
==============================

# wght_ram_mp

Multi-port distributed-RAM weight store for the sparse SNN core. It replaces the single-read weight buffer with three additions: a parametrised number of independent read channels, a flow-controlled write port, and a self-clearing initialisation sequence. It sits between the weight loader (write side) and the per-neuron-group accumulators (read side), so every channel can fetch a synaptic weight each cycle.

## Interface
Parameters:
- WGHT_WIDTH, 32, bits per weight word
- DEPTH, 32, number of words (≥2)
- NUM_RD, 2, number of read channels (1..8)
- RD_LAT, 1, read latency in cycles; legal values are 1 or 2
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted
- wr_addr  in  ADDR_W  write address
- wr_data  in  WGHT_WIDTH  write data
- rd_en  in  NUM_RD  per-channel read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; channel i is at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*WGHT_WIDTH  packed read data
- rd_valid  out  NUM_RD  per-channel data valid
- init_done  out  1  clear sequence complete

## Operation
- FSM states:
  - S_CLEAR: counter clr_addr writes 0 to mem[clr_addr] each cycle and increments.
    - When clr_addr == DEPTH-1, that write completes, the FSM moves to S_READY and clr_addr holds.
    - wr_ready = 0, init_done = 0.
    - rd_en is ignored; no rd_valid is produced.
  - S_READY: wr_ready = 1 and init_done = 1.
    - A write occurs when wr_valid && wr_ready: mem[wr_addr] <= wr_data.
  - Any other state encoding returns to S_CLEAR.
- Reads in S_READY:
  - Channel i samples mem[rd_addr_i] when rd_en[i] = 1.
  - Data and rd_valid[i] appear RD_LAT cycles later.
  - Channels are fully independent, and any number of them may hit the same address.
- Read-during-write to the same address in the same cycle: write-first. rd_data returns the new wr_data through a bypass mux.
- rd_data holds its last value when no read completes; rd_valid pulses for exactly one cycle per accepted request.
- Out-of-range addresses (DEPTH not a power of 2) are undefined for reads and dropped for writes.
- The memory array carries no reset and is inferred as distributed RAM. Only the FSM, the counter, the pipeline valids and rd_data are reset.

## Timing
- Reset values: wr_ready = 0, init_done = 0, rd_valid = 0, rd_data = 0, state = S_CLEAR, clr_addr = 0.
- Clear duration: DEPTH rising edges after rst deasserts.
  - init_done and wr_ready go high after the DEPTH-th edge.
  - Example: DEPTH = 32 gives a first accepted write on edge 33.
- Read latency:
  - RD_LAT = 1: request on edge n, data registered on edge n.
  - RD_LAT = 2: one extra output register stage, data on edge n+1.
- Write latency: a write on edge n is visible to a read issued on edge n (bypass) and on all later edges.
- Reset mid-operation:
  - All in-flight rd_valid bits are dropped immediately (asynchronously).
  - The FSM restarts S_CLEAR from address 0, and memory contents are re-cleared.
- Throughput: one write plus NUM_RD reads per cycle, with no stalls once init_done = 1.

## Structure
- Package wght_ram_pkg:
  - typedef enum logic [0:0] {S_CLEAR, S_READY} wram_state_t
  - localparam RD_LAT_MAX = 2
- Sub-module wght_rd_pipe, instantiated NUM_RD times. Each instance contains:
  - the address-compare write bypass mux
  - the 1- or 2-stage data/valid pipeline selected by RD_LAT
- The top level holds the FSM, the clear counter, the memory array with its write-port mux (clear write vs. user write) and the per-channel asynchronous array reads.

## Test plan
- Reset then idle, DEPTH = 32:
  - init_done rises exactly 32 edges after rst falls.
  - Reads of every address return 0x00000000 with rd_valid after RD_LAT.
- Write 0xDEADBEEF to address 5, then read address 5 on both channels next cycle -> both rd_data = 0xDEADBEEF, and both rd_valid pulse once after RD_LAT.
- Same-cycle write 0x12345678 to address 9 and channel 0 reads address 9 -> channel 0 returns 0x12345678 (write-first).
- During S_CLEAR, drive wr_valid = 1 and rd_en = 2'b11 -> wr_ready = 0, no rd_valid pulses, memory stays zero afterwards.
- Back-to-back reads on channel 1 at addresses 0..31 with RD_LAT = 2 -> 32 consecutive rd_valid cycles, each 2 cycles after its request, with data matching the written pattern.
- Assert rst with a read in flight after writing address 3 -> rd_valid drops at once; after the new clear, address 3 reads as 0.

Source files
------------

// File: rtl/wght_ram_mp_pkg.sv
// Shared types for the multi-port weight store.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wght_ram_pkg;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } wram_state_t;

    // Deepest read pipeline a channel can be built with.
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/wght_ram_mp_if.sv
// Loader/accumulator bundle: one flow-controlled write port plus NUM_RD read channels.
// Latency: n/a (wiring only).
// Backpressure: the write side stalls on wr_ready; the read side has none.
interface wght_ram_mp_if #(
    parameter int WGHT_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int ADDR_W     = $clog2(DEPTH)
);

    logic                         wr_valid;
    logic                         wr_ready;
    logic [ADDR_W-1:0]            wr_addr;
    logic [WGHT_WIDTH-1:0]        wr_data;
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_W-1:0]     rd_addr;
    logic [NUM_RD*WGHT_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_valid;
    logic                         init_done;

    // Weight loader and accumulators drive requests.
    modport master (
        output wr_valid, wr_addr, wr_data, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid, init_done
    );

    // The RAM answers them.
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid, init_done
    );

endinterface

// File: rtl/wght_ram_mp_rd_pipe.sv
// One read channel: write-first bypass onto the array word, then a 1- or 2-stage output pipe.
// Latency: RD_LAT cycles from an accepted request to rd_valid_o.
// Backpressure: none; every accepted request produces exactly one rd_valid_o pulse.
module wght_rd_pipe
    import wght_ram_pkg::*;
#(
    parameter int WGHT_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    input  logic [WGHT_WIDTH-1:0] arr_data_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [WGHT_WIDTH-1:0] wr_data_i,
    output logic [WGHT_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    logic [WGHT_WIDTH-1:0] s1_data_d;
    logic [WGHT_WIDTH-1:0] s1_data_q;
    logic                  s1_vld_q;

    // A write landing on the same word this cycle wins over the stale array contents.
    always_comb begin
        s1_data_d = arr_data_i;
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            s1_data_d = wr_data_i;
        end
    end

    // First stage: capture data only on a request so the output holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q <= rd_req_i;
            if (rd_req_i) begin
                s1_data_q <= s1_data_d;
            end
        end
    end

    if (RD_LAT >= RD_LAT_MAX) begin : g_two_stage
        logic [WGHT_WIDTH-1:0] s2_data_q;
        logic                  s2_vld_q;

        // Extra output register for timing; advances only behind a valid first stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_data_o  = s2_data_q;
        assign rd_valid_o = s2_vld_q;
    end else begin : g_one_stage
        assign rd_data_o  = s1_data_q;
        assign rd_valid_o = s1_vld_q;
    end

endmodule

// File: rtl/wght_ram_mp.sv
// Multi-port distributed-RAM weight store with self-clearing init and NUM_RD read channels.
// Latency: DEPTH cycles of clear after reset, then RD_LAT cycles per read, writes visible same cycle.
// Backpressure: wr_ready low only while clearing; reads are never stalled and ignored while clearing.
module wght_ram_mp
    import wght_ram_pkg::*;
#(
    parameter int WGHT_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    wght_ram_mp_if.slave ram
);

    localparam int unsigned     DEPTH_U  = DEPTH;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    // No reset on the array so it maps onto distributed RAM; the clear sequence zeroes it.
    logic [WGHT_WIDTH-1:0] mem [DEPTH];

    wram_state_t           state_q;
    logic [ADDR_W-1:0]     clr_addr_q;
    logic                  init_done_q;
    logic                  wr_ready_q;

    logic                  user_wr;
    logic                  rd_open;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [WGHT_WIDTH-1:0] mem_wdata;

    logic [NUM_RD-1:0]            rd_vld_w;
    logic [NUM_RD*WGHT_WIDTH-1:0] rd_dat_w;

    // Accepted user write; out-of-range addresses are dropped here.
    assign user_wr = ram.wr_valid && wr_ready_q && (32'(ram.wr_addr) < DEPTH_U);
    assign rd_open = (state_q == S_READY);

    // Clear walks every word once, then the store opens for traffic until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (clr_addr_q == CLR_LAST) begin
                        state_q     <= S_READY;
                        init_done_q <= 1'b1;
                        wr_ready_q  <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    end
                end
                S_READY: begin
                    state_q     <= S_READY;
                    init_done_q <= 1'b1;
                    wr_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= S_CLEAR;
                    clr_addr_q  <= '0;
                    init_done_q <= 1'b0;
                    wr_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the clear sequence and the loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
        end else if (user_wr) begin
            mem_we    = 1'b1;
            mem_waddr = ram.wr_addr;
            mem_wdata = ram.wr_data;
        end
    end

    // Array write; reads are asynchronous in the per-channel logic below.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0]     ch_addr;
        logic [WGHT_WIDTH-1:0] ch_arr;

        assign ch_addr = ram.rd_addr[i*ADDR_W +: ADDR_W];
        assign ch_arr  = mem[ch_addr];

        wght_rd_pipe #(
            .WGHT_WIDTH (WGHT_WIDTH),
            .ADDR_W     (ADDR_W),
            .RD_LAT     (RD_LAT)
        ) u_rd_pipe (
            .clk        (clk),
            .rst        (rst),
            .rd_req_i   (ram.rd_en[i] && rd_open),
            .rd_addr_i  (ch_addr),
            .arr_data_i (ch_arr),
            .wr_en_i    (user_wr),
            .wr_addr_i  (ram.wr_addr),
            .wr_data_i  (ram.wr_data),
            .rd_data_o  (rd_dat_w[i*WGHT_WIDTH +: WGHT_WIDTH]),
            .rd_valid_o (rd_vld_w[i])
        );
    end

    assign ram.rd_data   = rd_dat_w;
    assign ram.rd_valid  = rd_vld_w;
    assign ram.wr_ready  = wr_ready_q;
    assign ram.init_done = init_done_q;

endmodule

// File: tb/tb_wght_ram_mp.sv
// Bench for wght_ram_mp: one RD_LAT=1 and one RD_LAT=2 instance driven with identical stimulus.
// Latency: expected read data is queued at drive time with its due cycle and checked on negedges.
// Backpressure: write acceptance is predicted from the bench's own count of edges since reset.
module tb_wght_ram_mp;

    localparam int WW     = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              wr_valid = 1'b0;
    logic [AW-1:0]     wr_addr  = '0;
    logic [WW-1:0]     wr_data  = '0;
    logic [1:0]        rd_en    = '0;
    logic [2*AW-1:0]   rd_addr  = '0;

    wght_ram_mp_if #(.WGHT_WIDTH(WW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus1 ();
    wght_ram_mp_if #(.WGHT_WIDTH(WW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus2 ();

    assign bus1.wr_valid = wr_valid;
    assign bus1.wr_addr  = wr_addr;
    assign bus1.wr_data  = wr_data;
    assign bus1.rd_en    = rd_en;
    assign bus1.rd_addr  = rd_addr;
    assign bus2.wr_valid = wr_valid;
    assign bus2.wr_addr  = wr_addr;
    assign bus2.wr_data  = wr_data;
    assign bus2.rd_en    = rd_en;
    assign bus2.rd_addr  = rd_addr;

    wght_ram_mp #(.WGHT_WIDTH(WW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .RD_LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .ram (bus1)
    );

    wght_ram_mp #(.WGHT_WIDTH(WW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .RD_LAT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .ram (bus2)
    );

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic [1:0]    re;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [31:0]   e0;
        logic [31:0]   e1;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int edges  = 0;

    exp_t        sb_q [4][$];
    logic [31:0] model_mem [DEPTH];

    logic [1:0]  vld [2];
    logic [63:0] dat [2];
    assign vld[0] = bus1.rd_valid;
    assign vld[1] = bus2.rd_valid;
    assign dat[0] = bus1.rd_data;
    assign dat[1] = bus2.rd_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Monitor: ready flags every cycle, read results against the scoreboard.
    always @(negedge clk) begin
        logic        exp_rdy;
        logic        v;
        logic [31:0] x;
        bit          ev;
        int          k;
        exp_rdy = (!rst) && (edges >= DEPTH);
        checks++;
        if (bus1.init_done !== exp_rdy || bus2.init_done !== exp_rdy ||
            bus1.wr_ready !== exp_rdy || bus2.wr_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready_flags cyc=%0d: init_done=%b/%b wr_ready=%b/%b want %b",
                     cyc, bus1.init_done, bus2.init_done, bus1.wr_ready, bus2.wr_ready, exp_rdy);
        end
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                k  = d * 2 + c;
                v  = vld[d][c];
                x  = dat[d][c*32 +: 32];
                ev = (sb_q[k].size() > 0) && (sb_q[k][0].due == cyc);
                if (v !== 1'b0 || ev) begin
                    checks++;
                    if (ev && v === 1'b1) begin
                        if (x !== sb_q[k][0].dat) begin
                            errors++;
                            $display("FAIL rd_data lat%0d ch%0d cyc=%0d: got %h want %h",
                                     d + 1, c, cyc, x, sb_q[k][0].dat);
                        end
                    end else if (ev) begin
                        errors++;
                        $display("FAIL rd_valid_missing lat%0d ch%0d cyc=%0d: got %b want 1",
                                 d + 1, c, cyc, v);
                    end else begin
                        errors++;
                        $display("FAIL rd_valid_unexpected lat%0d ch%0d cyc=%0d: got %b want 0",
                                 d + 1, c, cyc, v);
                    end
                    if (ev) void'(sb_q[k].pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; expectations use the table values or the bench memory model.
    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic [31:0] e0, input logic [31:0] e1, input bit use_model);
        bit            rdy;
        exp_t          e;
        logic [AW-1:0] ra [2];
        logic [31:0]   ex [2];
        rdy      = (!rst) && (edges >= DEPTH);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en    = re;
        rd_addr  = {ra1, ra0};
        ra[0] = ra0;
        ra[1] = ra1;
        ex[0] = e0;
        ex[1] = e1;
        if (rdy && wv) model_mem[wa] = wd;
        if (rdy) begin
            for (int c = 0; c < 2; c++) begin
                if (re[c]) begin
                    for (int d = 0; d < 2; d++) begin
                        e.dat = use_model ? model_mem[ra[c]] : ex[c];
                        e.due = cyc + 1 + d;
                        sb_q[d*2+c].push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 2'b00, '0, '0, '0, '0, 1'b1);
    endtask

    task automatic wait_ready();
        for (int t = 0; t < 200 && edges < DEPTH; t++) idle();
    endtask

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wa, ra0, ra1;

        foreach (model_mem[i]) model_mem[i] = '0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd9,  32'h12345678, 2'b11, 5'd9,  5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd9,  5'd0,  32'h12345678, 32'h0};
        vecs[4] = '{1'b1, 5'd5,  32'h0BADF00D, 2'b11, 5'd5,  5'd5,  32'h0BADF00D, 32'h0BADF00D};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd9,  32'h0,        32'h12345678};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 2'b10, 5'd0,  5'd31, 32'h0,        32'hFFFFFFFF};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus1.rd_valid !== 2'b00 || bus2.rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_rd_valid: got %b/%b want 00", bus1.rd_valid, bus2.rd_valid);
        end
        checks++;
        if (bus1.rd_data !== 64'h0 || bus2.rd_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h/%h want 0", bus1.rd_data, bus2.rd_data);
        end
        checks++;
        if (bus1.init_done !== 1'b0 || bus2.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got init_done=%b wr_ready=%b want 0/0",
                     bus1.init_done, bus2.wr_ready);
        end
        rst = 1'b0;

        // Writes and reads during the clear must be ignored; address 0 is already cleared by edge 1.
        for (int i = 0; i < 20; i++) drive(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'(i), 5'(i), '0, '0, 1'b1);
        wait_ready();

        // Every word reads as zero after the clear.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 2'b11, 5'(i), 5'(DEPTH - 1 - i), '0, '0, 1'b1);

        // Directed table: write/read, write-first bypass on both channels.
        for (int i = 0; i < 8; i++)
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra0, vecs[i].ra1,
                  vecs[i].e0, vecs[i].e1, 1'b0);

        // Fill a pattern, then 32 back-to-back reads on channel 1.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 5'(i), $urandom, 2'b00, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 2'b10, '0, 5'(i), '0, '0, 1'b1);

        // Random traffic with frequent same-address collisions.
        for (int i = 0; i < 150; i++) begin
            wa  = 5'($urandom_range(0, 31));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, 2'($urandom_range(0, 3)), ra0, ra1, '0, '0, 1'b1);
        end
        repeat (3) idle();

        // Reset with reads in flight after writing address 3.
        drive(1'b1, 5'd3, 32'hCAFEF00D, 2'b00, '0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, 2'b11, 5'd3, 5'd3, '0, '0, 1'b1);
        checks++;
        if (bus1.rd_valid !== 2'b11 || bus1.rd_data !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL pre_reset_read: got vld=%b dat=%h want 11 cafef00dcafef00d",
                     bus1.rd_valid, bus1.rd_data);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) sb_q[k].delete();
        foreach (model_mem[i]) model_mem[i] = '0;
        #1;
        checks++;
        if (bus1.rd_valid !== 2'b00 || bus2.rd_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_drops_valid: got %b/%b want 00/00", bus1.rd_valid, bus2.rd_valid);
        end
        rd_en = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready();
        drive(1'b0, '0, '0, 2'b11, 5'd3, 5'd3, '0, '0, 1'b1);
        repeat (4) idle();

        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sb_q[k].size() != 0) begin
                errors++;
                $display("FAIL drain lat%0d ch%0d: got %0d pending want 0", k / 2 + 1, k % 2, sb_q[k].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
